multicycle_control: RTL and testbench

Multi-cycle sequencer for the 31-instruction MIPS core. It replaces single-cycle combinational control with a state machine. The block takes the one-hot instruction vector from the decoder, the ALU `zero` flag and ready handshakes from instruction and data memory. It drives per-phase enables for PC, IR, ALU, data memory and register file, and selects the PC source. It also detects malformed opcodes into a sticky trap and keeps cycle and retired-instruction counters.

---
 rtl/multicycle_control.sv | 163 ++++++++++++++++
 tb/tb_multicycle_control.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the 31-instruction MIPS core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP.
module multicycle_control #(
    parameter int              N_OP        = 31,
    parameter int              CNT_W       = 32,
    parameter logic [N_OP-1:0] LOAD_MASK   = 31'h0100_0000,
    parameter logic [N_OP-1:0] STORE_MASK  = 31'h0200_0000,
    parameter logic [N_OP-1:0] BRANCH_MASK = 31'h0C00_0000,
    parameter logic [N_OP-1:0] BNE_MASK    = 31'h0800_0000,
    parameter logic [N_OP-1:0] JUMP_MASK   = 31'h7000_0000,
    parameter logic [N_OP-1:0] NOWB_MASK   = 31'h5E00_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_OP-1:0]  op,
    input  logic             zero,
    input  logic             im_ready,
    input  logic             dm_ready,
    output logic             im_req,
    output logic             ir_we,
    output logic             alu_en,
    output logic             dm_cs,
    output logic             dm_r,
    output logic             dm_w,
    output logic             rf_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             retire,
    output logic             trap,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cycle_q;
    logic [CNT_W-1:0]   instret_q;

    logic is_ld;
    logic is_st;
    logic is_br;
    logic is_bne;
    logic is_jmp;
    logic is_nowb;
    logic onehot;
    logic taken;

    assign is_ld   = |(op & LOAD_MASK);
    assign is_st   = |(op & STORE_MASK);
    assign is_br   = |(op & BRANCH_MASK);
    assign is_bne  = |(op & BNE_MASK);
    assign is_jmp  = |(op & JUMP_MASK);
    assign is_nowb = |(op & NOWB_MASK);
    assign onehot  = (op != '0) && ((op & (op - N_OP'(1))) == '0);
    assign taken   = is_bne ? ~zero : zero;

    // Next state and per-phase strobes; everything is held low during reset.
    always_comb begin
        state_d = state_q;
        im_req  = 1'b0;
        ir_we   = 1'b0;
        alu_en  = 1'b0;
        dm_cs   = 1'b0;
        dm_r    = 1'b0;
        dm_w    = 1'b0;
        rf_we   = 1'b0;
        pc_we   = 1'b0;
        pc_src  = 2'd0;
        retire  = 1'b0;
        trap    = 1'b0;
        if (!rst) begin
            unique case (state_q)
                S_FETCH: begin
                    im_req = 1'b1;
                    ir_we  = im_ready;
                    if (im_ready) state_d = S_DECODE;
                end
                S_DECODE: begin
                    state_d = onehot ? S_EXEC : S_TRAP;
                end
                S_EXEC: begin
                    alu_en = 1'b1;
                    if (is_ld || is_st) begin
                        state_d = S_MEM;
                    end else if (is_br) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        pc_src  = taken ? 2'd1 : 2'd0;
                        state_d = S_FETCH;
                    end else if (is_jmp) begin
                        if (is_nowb) begin
                            pc_we   = 1'b1;
                            retire  = 1'b1;
                            pc_src  = 2'd2;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end else if (is_nowb) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
                S_MEM: begin
                    dm_cs = 1'b1;
                    dm_r  = is_ld;
                    dm_w  = ~is_ld & is_st;
                    if (dm_ready) begin
                        if (is_ld) begin
                            state_d = S_WB;
                        end else begin
                            pc_we   = 1'b1;
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    rf_we   = 1'b1;
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    pc_src  = is_jmp ? 2'd2 : 2'd0;
                    state_d = S_FETCH;
                end
                S_TRAP: begin
                    trap = 1'b1;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    // State register and performance counters; the cycle count freezes in TRAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != S_TRAP) cycle_q <= cycle_q + CNT_W'(1);
            if (retire) instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control.
// Table of instructions plus hand sequences for trap, wrap and reset abort.
module tb_multicycle_control;

    localparam logic [30:0] OP_LD  = 31'h0100_0000;
    localparam logic [30:0] OP_ST  = 31'h0200_0000;
    localparam logic [30:0] OP_BEQ = 31'h0400_0000;
    localparam logic [30:0] OP_BNE = 31'h0800_0000;
    localparam logic [30:0] OP_J28 = 31'h1000_0000;
    localparam logic [30:0] OP_J29 = 31'h2000_0000;
    localparam logic [30:0] OP_J30 = 31'h4000_0000;

    typedef struct {
        logic [30:0] op;
        logic        zero;
        int          im_wait;
        int          dm_wait;
        int          lat;
        logic [1:0]  src;
        logic        rf;
        int          dmcyc;
        logic        dmr;
        logic        dmw;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [30:0] op;
    logic        zero;
    logic        im_ready;
    logic        dm_ready;
    logic        im_req, ir_we, alu_en, dm_cs, dm_r, dm_w;
    logic        rf_we, pc_we, retire, trap;
    logic [1:0]  pc_src;
    logic [31:0] cycle_cnt, instret_cnt;
    logic        im_req4, ir_we4, alu_en4, dm_cs4, dm_r4, dm_w4;
    logic        rf_we4, pc_we4, retire4, trap4;
    logic [1:0]  pc_src4;
    logic [3:0]  cycle_cnt4, instret_cnt4;

    int errors = 0;
    int checks = 0;
    int exp_cyc = 0;
    int exp_ret = 0;
    vec_t sb[$];
    vec_t tbl[13];

    multicycle_control dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero),
        .im_ready(im_ready), .dm_ready(dm_ready),
        .im_req(im_req), .ir_we(ir_we), .alu_en(alu_en),
        .dm_cs(dm_cs), .dm_r(dm_r), .dm_w(dm_w),
        .rf_we(rf_we), .pc_we(pc_we), .pc_src(pc_src),
        .retire(retire), .trap(trap),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    multicycle_control #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .op(op), .zero(zero),
        .im_ready(im_ready), .dm_ready(dm_ready),
        .im_req(im_req4), .ir_we(ir_we4), .alu_en(alu_en4),
        .dm_cs(dm_cs4), .dm_r(dm_r4), .dm_w(dm_w4),
        .rf_we(rf_we4), .pc_we(pc_we4), .pc_src(pc_src4),
        .retire(retire4), .trap(trap4),
        .cycle_cnt(cycle_cnt4), .instret_cnt(instret_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [12:0] strobes();
        return {im_req, ir_we, alu_en, dm_cs, dm_r, dm_w,
                rf_we, pc_we, pc_src, retire, trap, 1'b0};
    endfunction

    // Asynchronous reset: everything must clear at once.
    task automatic do_reset();
        rst = 1'b1;
        im_ready = 1'b1;
        dm_ready = 1'b1;
        op = 31'h1;
        zero = 1'b0;
        #1;
        chk("rst_outputs", strobes(), 0);
        chk("rst_cycle", cycle_cnt, 0);
        chk("rst_instret", instret_cnt, 0);
        chk("rst_trap", trap, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_cyc = 0;
        exp_ret = 0;
    endtask

    // Runs one instruction starting at a negedge in FETCH.
    task automatic run_instr(input vec_t v);
        int c = 0;
        int dmc = 0;
        int irc = 0;
        int pwc = 0;
        int bad = 0;
        logic rd = 1'b0;
        logic wr = 1'b0;
        logic done = 1'b0;
        vec_t e;
        chk("cycle_cnt", cycle_cnt, exp_cyc);
        chk("instret_cnt", instret_cnt, exp_ret);
        chk("instret_cnt4", instret_cnt4, exp_ret % 16);
        sb.push_back(v);
        op = v.op;
        zero = v.zero;
        while (!done && c < 60) begin
            c++;
            im_ready = (c > v.im_wait);
            dm_ready = (c >= v.im_wait + 4 + v.dm_wait);
            #1;
            if (ir_we) irc++;
            if (dm_cs) dmc++;
            if (dm_r) rd = 1'b1;
            if (dm_w) wr = 1'b1;
            if (pc_we) pwc++;
            if (pc_we != retire) bad++;
            if (!pc_we && pc_src != 2'd0) bad++;
            if (c <= v.im_wait + 1 && !im_req) bad++;
            if (retire) begin
                done = 1'b1;
                e = sb.pop_front();
                chk("latency", c, e.lat);
                chk("pc_src", pc_src, e.src);
                chk("rf_we", rf_we, e.rf);
            end
            @(negedge clk);
        end
        if (!done) begin
            chk("retire_timeout", 0, 1);
            void'(sb.pop_front());
        end
        chk("dm_cs_cycles", dmc, v.dmcyc);
        chk("dm_r", rd, v.dmr);
        chk("dm_w", wr, v.dmw);
        chk("ir_we_count", irc, 1);
        chk("pc_we_count", pwc, 1);
        chk("strobe_rules", bad, 0);
        exp_cyc += c;
        exp_ret++;
    endtask

    // Illegal opcode must trap after DECODE and freeze everything.
    task automatic trap_test(input logic [30:0] bad_op);
        logic [31:0] c0;
        int leak = 0;
        int moved = 0;
        do_reset();
        op = bad_op;
        im_ready = 1'b1;
        #1;
        chk("trap_fetch_req", im_req, 1);
        @(negedge clk);
        #1;
        chk("trap_decode", trap, 0);
        @(negedge clk);
        #1;
        chk("trap_set", trap, 1);
        c0 = cycle_cnt;
        chk("trap_cycle_at_entry", c0, 2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (strobes() != 13'b0000000000010) leak++;
            if (cycle_cnt != c0) moved++;
        end
        chk("trap_strobes", leak, 0);
        chk("trap_cycle_frozen", moved, 0);
        do_reset();
    endtask

    initial begin
        vec_t st;
        tbl[0]  = '{31'h1,  1'b0, 0, 0, 4, 2'd0, 1'b1, 0, 1'b0, 1'b0};
        tbl[1]  = '{OP_LD,  1'b0, 0, 3, 8, 2'd0, 1'b1, 4, 1'b1, 1'b0};
        tbl[2]  = '{OP_ST,  1'b0, 0, 0, 4, 2'd0, 1'b0, 1, 1'b0, 1'b1};
        tbl[3]  = '{OP_BEQ, 1'b1, 0, 0, 3, 2'd1, 1'b0, 0, 1'b0, 1'b0};
        tbl[4]  = '{OP_BNE, 1'b1, 0, 0, 3, 2'd0, 1'b0, 0, 1'b0, 1'b0};
        tbl[5]  = '{OP_BNE, 1'b0, 0, 0, 3, 2'd1, 1'b0, 0, 1'b0, 1'b0};
        tbl[6]  = '{OP_BEQ, 1'b0, 0, 0, 3, 2'd0, 1'b0, 0, 1'b0, 1'b0};
        tbl[7]  = '{OP_J29, 1'b0, 0, 0, 4, 2'd2, 1'b1, 0, 1'b0, 1'b0};
        tbl[8]  = '{OP_J28, 1'b0, 0, 0, 3, 2'd2, 1'b0, 0, 1'b0, 1'b0};
        tbl[9]  = '{OP_J30, 1'b1, 0, 0, 3, 2'd2, 1'b0, 0, 1'b0, 1'b0};
        tbl[10] = '{31'h20, 1'b0, 2, 0, 6, 2'd0, 1'b1, 0, 1'b0, 1'b0};
        tbl[11] = '{OP_ST,  1'b0, 1, 2, 7, 2'd0, 1'b0, 3, 1'b0, 1'b1};
        tbl[12] = '{31'h8,  1'b1, 0, 0, 4, 2'd0, 1'b1, 0, 1'b0, 1'b0};

        do_reset();
        for (int i = 0; i < 13; i++) run_instr(tbl[i]);
        chk("instret_total", instret_cnt, 13);

        trap_test(31'h0);
        trap_test(31'h3);

        st = tbl[2];
        for (int i = 0; i < 16; i++) run_instr(st);
        chk("instret4_wrap", instret_cnt4, 0);
        chk("instret_16", instret_cnt, 16);

        // Abort a store while it waits in MEM.
        do_reset();
        op = OP_ST;
        im_ready = 1'b1;
        dm_ready = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        #1;
        chk("abort_dm_cs_before", dm_cs, 1);
        chk("abort_dm_w_before", dm_w, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_dm_cs", dm_cs, 0);
        chk("abort_retire", retire, 0);
        chk("abort_pc_we", pc_we, 0);
        chk("abort_cycle", cycle_cnt, 0);
        chk("abort_instret", instret_cnt, 0);
        @(negedge clk);
        dm_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cyc = 0;
        exp_ret = 0;
        run_instr(tbl[0]);
        chk("after_abort_instret", instret_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
